if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//   Instruction fetch stage sitting directly upstream of the instruction ROM.
//   - Drives the ROM byte address and samples the 32-bit little-endian word the ROM returns in the same cycle.
//   - Buffers {pc, instr} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
//   - Handles redirects, and raises finish when the halt instruction is fetched (finish_o feeds the ROM's finish input).
// PARAMETERS
//   RESET_PC    64'h0          PC loaded on reset.
//   FIFO_DEPTH  2              Entries in the fetch buffer; must be >= 2.
//   HALT_INSN   32'h0010_0073  Encoding (ebreak) that ends fetching.
// PORTS
//   clk_i            in   1   Clock; all state updates on the rising edge.
//   rst_i            in   1   Reset; synchronous, active-high.
//   start_i          in   1   Start pulse (driven by the ROM load-done/write_en pulse).
//   rom_addr_o       out  64  Byte address to ROM; equals pc_q.
//   rom_data_i       in   32  Instruction word at rom_addr_o, valid in the same cycle.
//   finish_o         out  1   Halt reached; to ROM finish input.
//   redirect_i       in   1   Redirect request (branch/jump/trap).
//   redirect_pc_i    in   64  Redirect target.
//   out_valid_o      out  1   FIFO head valid.
//   out_ready_i      in   1   Decode accepts the head.
//   out_pc_o         out  64  PC of the head entry.
//   out_instr_o      out  32  Instruction of the head entry.
//   misalign_o       out  1   Sticky: a redirect target had pc[1:0] != 0.
// BEHAVIOUR
//   - Reset values:
//     - state = IDLE; pc_q = RESET_PC; FIFO count = 0.
//     - out_valid_o = 0; finish_o = 0; misalign_o = 0; out_pc_o/out_instr_o = 0.
//   - IDLE:
//     - No pushes.
//     - start_i = 1 -> FETCH.
//     - redirect_i updates pc_q only.
//   - FETCH:
//     - push = (count < FIFO_DEPTH) && !redirect_i.
//     - On push: write {pc_q, rom_data_i}; pc_q <= pc_q + 4 (mod 2^64).
//     - Full-rate behaviour: one word per cycle while out_ready_i = 1; latency from push to out_valid_o is 1 cycle.
//     - If a pushed word == HALT_INSN: state -> HALT; finish_o = 1 from the next cycle. The halt word itself is delivered.
//   - HALT:
//     - No further pushes; remaining entries drain normally.
//     - redirect_i and start_i are ignored; leaves HALT only via rst_i.
//   - Redirect (priority over push, IDLE/FETCH only):
//     - Flush the FIFO (count = 0); out_valid_o = 0 from the next cycle.
//     - pc_q <= {redirect_pc_i[63:2], 2'b00}.
//     - If redirect_pc_i[1:0] != 0, set misalign_o (sticky until reset).
//   - Push and pop in the same cycle:
//     - Full is judged on the registered count, so a pop does not free a slot for a push in that same cycle.
//     - With count < DEPTH, simultaneous push and pop keeps count unchanged.
//   - Pop occurs when out_valid_o && out_ready_i.
//   - The ROM decodes rom_addr_o[9:0] only, so fetch wraps within 1 KiB; the full 64-bit pc_q is still reported.
//   - rst_i mid-operation restores all reset values on the next edge; a new start_i is required.
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined:
//     - Adds outputs perf_fetched_o[63:0] (pushes) and perf_stall_o[63:0] (FETCH cycles with a full FIFO).
//     - Both counters are 0 on reset and wrap at 2^64.
//   Macro undefined: those ports and counters do not exist.
// STRUCTURE
//   Package fetch_pkg:
//     - State enum (IDLE, FETCH, HALT).
//     - Default HALT_INSN.
//     - Instruction width (32) and address width (64) constants.
//   Sub-module fetch_fifo:
//     - Parameterised synchronous FIFO with flush, push, pop and count.
//     - Carries {pc, instr}.
// TESTING
//   1. Reset, start_i pulse, out_ready_i = 1:
//      - Outputs pc 0x0, 0x4, 0x8 in consecutive cycles, with instructions matching ROM words.
//   2. out_ready_i = 0 for 5 cycles after start:
//      - count saturates at 2; pc_q holds at 0x8.
//      - On release: pc 0x0 then 0x4, no loss or duplication.
//   3. Redirect to 0x40 while the FIFO is full:
//      - Next cycle out_valid_o = 0; the first delivered pc is 0x40.
//   4. ebreak (0x00100073) at 0xC:
//      - Delivered with out_pc_o = 0xC; finish_o rises the cycle after its push and stays 1.
//      - No push from 0x10; a later redirect is ignored.
//   5. Redirect to 0x42:
//      - misalign_o = 1 and stays 1; fetching resumes at 0x40.
//   6. rst_i asserted in FETCH with entries buffered:
//      - Next cycle: all outputs at reset values; no fetch until start_i.
//      - With FETCH_PERF_CNT_EN: after scenario 2, perf_stall_o = 3 and perf_fetched_o = 2.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] HALT_INSN_DEFAULT = 32'h0010_0073;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched {pc, instr} entries with a single-cycle flush.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o
);

    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && (count_q != FULL_COUNT);
    assign do_pop  = pop_i && !empty_o;
    // Head reads as zero when empty so the outputs are clean after reset/flush.
    assign rdata_o = empty_o ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (do_push && !do_pop)
                count_q <= count_q + CW'(1);
            else if (!do_push && do_pop)
                count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i && !rst_i)
            mem[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: drives the ROM address and buffers {pc, instr} for decode.
// Defining FETCH_PERF_CNT_EN adds push and full-stall performance counters.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [ILEN-1:0] HALT_INSN  = HALT_INSN_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic [XLEN-1:0] rom_addr_o,
    input  logic [ILEN-1:0] rom_data_i,
    output logic            finish_o,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [ILEN-1:0] out_instr_o,
    output logic            misalign_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [63:0]     perf_fetched_o,
    output logic [63:0]     perf_stall_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic            redirect_take;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    wr_entry;
    fetch_entry_t    rd_entry;

    assign redirect_take = redirect_i && (state_q != HALT);
    // Fullness uses the registered count, so a same-cycle pop never frees a slot.
    assign push        = (state_q == FETCH) && (fifo_count < CW'(FIFO_DEPTH)) && !redirect_i;
    assign pop         = out_valid_o && out_ready_i;
    assign wr_entry    = '{pc: pc_q, instr: rom_data_i};
    assign rom_addr_o  = pc_q;
    assign out_valid_o = !fifo_empty;
    assign out_pc_o    = rd_entry.pc;
    assign out_instr_o = rd_entry.instr;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_take),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (rd_entry),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            finish_o   <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            if (redirect_take) begin
                pc_q <= {redirect_pc_i[XLEN-1:2], 2'b00};
                if (redirect_pc_i[1:0] != 2'b00) misalign_o <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start_i) state_q <= FETCH;
                end
                FETCH: begin
                    if (push) begin
                        pc_q <= pc_q + XLEN'(4);
                        if (rom_data_i == HALT_INSN) begin
                            state_q  <= HALT;
                            finish_o <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fetched_o <= '0;
            perf_stall_o   <= '0;
        end else begin
            if (push) perf_fetched_o <= perf_fetched_o + 64'd1;
            if ((state_q == FETCH) && (fifo_count == CW'(FIFO_DEPTH)))
                perf_stall_o <= perf_stall_o + 64'd1;
        end
    end
`endif

endmodule
